// File: rtl/multiword_addsub_seq.sv
// multiword_addsub_seq
// Wide two's-complement add/subtract built from a single 4-bit slice that is
// stepped over NIBBLES nibbles, LSB first, with the carry held between cycles.
// Operands arrive over a valid/ready handshake. The result, carry and signed
// overflow are then held on a valid/ready output until the consumer takes them.
// Optional feature macro: ADDSUB_SAT_EN. When it is defined, an overflowing
// result is clamped to max-positive or min-negative as it enters DONE.
module multiword_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4*NIBBLES-1:0]   a_i,
  input  logic [4*NIBBLES-1:0]   b_i,
  input  logic                   sub_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4*NIBBLES-1:0]   result_o,
  output logic                   carry_o,
  output logic                   ovf_o,
  output logic                   busy_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cin_q, cin_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;

  logic [CW+1:0]   idx_s;
  logic [3:0]      a_nib_s;
  logic [3:0]      t_nib_s;
  logic [4:0]      sum_s;
  logic            last_s;
  logic            ovf_s;

  // The 4-bit slice working on the nibble selected by cnt. B is inverted for subtract.
  always_comb begin
    idx_s   = {cnt_q, 2'b00};
    a_nib_s = a_q[idx_s +: 4];
    t_nib_s = b_q[idx_s +: 4] ^ {4{sub_q}};
    sum_s   = {1'b0, a_nib_s} + {1'b0, t_nib_s} + {4'b0000, cin_q};
    last_s  = (cnt_q == LAST);
    // Only meaningful on the MSB slice, where a_nib_s[3] is the sign of A.
    ovf_s   = (a_nib_s[3] == t_nib_s[3]) && (sum_s[3] != a_nib_s[3]);
  end

  // Next-state logic: capture operands in IDLE, step slices in RUN, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          cnt_d   = '0;
          cin_d   = sub_i;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[idx_s +: 4] = sum_s[3:0];
        cin_d                = sum_s[4];
        if (last_s) begin
          carry_d = sum_s[4];
          ovf_d   = ovf_s;
          state_d = ST_DONE;
`ifdef ADDSUB_SAT_EN
          // Clamp toward the sign of A. Carry and ovf still report the raw values.
          if (ovf_s) begin
            if (a_nib_s[3]) begin
              result_d = {1'b1, {(W-1){1'b0}}};
            end else begin
              result_d = {1'b0, {(W-1){1'b1}}};
            end
          end else begin
            result_d[idx_s +: 4] = sum_s[3:0];
          end
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset takes priority and drops any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN);
  assign result_o    = result_q;
  assign carry_o     = carry_q;
  assign ovf_o       = ovf_q;

endmodule
